// File: rtl/stage_ex_muldiv_pkg.sv
// Shared definitions for the EX stage and its multiply/divide unit.
//   aluOp_e   : ALUctr encodings (12..15 are unused and yield 0)
//   mdOp_e    : MD_op encodings (MD_MT writes HI or LO, selected by Shamt[0])
//   mdState_e : multiply/divide sequencer states
package stage_ex_muldiv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } aluOp_e;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MFHI  = 3'd5,
      MD_MFLO  = 3'd6,
      MD_MT    = 3'd7
   } mdOp_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } mdState_e;

endpackage

// File: rtl/stage_ex_muldiv_if.sv
// EX stage bus: operands and controls coming from ID/EX, results going to
// EX/MEM, plus the stall/flush handshake.
// Handshake: the stage holds the instruction in EX while ex_stall is 1; the
// upstream must keep SrcA/SrcB/Shamt/ALUctr/MD_op stable in those cycles.
// mem_stall freezes the EX/MEM handoff (no new mul/div is accepted), and
// flush kills whatever is in EX in that same cycle.
//   master : upstream/pipeline control side (drives operands, reads results)
//   slave  : the EX stage
//   mdState is a debug view of the multiply/divide sequencer.
interface stage_ex_muldiv_if #(
   parameter int XLEN = 32
);
   import stage_ex_muldiv_pkg::*;

   logic [XLEN-1:0] SrcA;
   logic [XLEN-1:0] SrcB;
   logic [4:0]      Shamt;
   logic [3:0]      ALUctr;
   logic [2:0]      MD_op;
   logic            mem_stall;
   logic            flush;
   logic [XLEN-1:0] ALUres;
   logic [XLEN-1:0] MemWd;
   logic            Zero;
   logic            ex_stall;
   logic [XLEN-1:0] HI;
   logic [XLEN-1:0] LO;
   mdState_e        mdState;

   modport master (
      output SrcA, SrcB, Shamt, ALUctr, MD_op, mem_stall, flush,
      input  ALUres, MemWd, Zero, ex_stall, HI, LO, mdState
   );

   modport slave (
      input  SrcA, SrcB, Shamt, ALUctr, MD_op, mem_stall, flush,
      output ALUres, MemWd, Zero, ex_stall, HI, LO, mdState
   );

endinterface

// File: rtl/stage_ex_muldiv_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
//   op    : MD_op of the instruction (mult/multu/div/divu/mt)
//   a, b  : rs / rt operands
//   start : launch op (or perform the mthi/mtlo write) this cycle; only
//           meaningful in IDLE
//   mtLo  : for MD_MT, 1 writes LO, 0 writes HI
//   flush : abandon an operation in flight without touching HI/LO
//   busy  : state != IDLE
//   state : sequencer state (debug)
//   HI/LO : architectural registers
module stage_ex_muldiv_muldiv_unit
   import stage_ex_muldiv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MD_ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            start,
   input  logic            mtLo,
   input  logic            flush,
   output logic            busy,
   output mdState_e        state,
   output logic [XLEN-1:0] HI,
   output logic [XLEN-1:0] LO
);

   localparam int CW = $clog2(MD_ITER + 1);

   logic [CW-1:0]     cnt;
   // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
   logic [XLEN-1:0]   origA;    // raw dividend, returned in HI on divide-by-zero
   logic              signA, signB, isDiv, bZero;

   logic              isSigned, opDiv, opMd, negA, negB;
   logic [XLEN-1:0]   magA, magB;
   logic [XLEN:0]     addSum, shifted, diff;
   logic [2*XLEN-1:0] accNext, prodFix;
   logic [XLEN-1:0]   quoFix, remFix;

   always_comb begin
      isSigned = (op == MD_MULT) || (op == MD_DIV);
      opDiv    = (op == MD_DIV) || (op == MD_DIVU);
      opMd     = (op == MD_MULT) || (op == MD_MULTU) || opDiv;
      negA     = isSigned & a[XLEN-1];
      negB     = isSigned & b[XLEN-1];
      magA     = negA ? -a : a;
      magB     = negB ? -b : b;
   end

   // One radix-2 step. The multiply add keeps its carry so the right shift
   // brings it into the product; the divide keeps the remainder only when
   // the trial subtraction does not borrow (restoring division).
   always_comb begin
      addSum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
      shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff    = shifted - {1'b0, opnd};
      accNext = acc;
      if (isDiv) begin
         if (!diff[XLEN]) accNext = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else             accNext = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else if (acc[0]) begin
         accNext = {addSum, acc[XLEN-1:1]};
      end else begin
         accNext = {1'b0, acc[2*XLEN-1:1]};
      end
   end

   // Sign fixups: product and quotient take signA^signB, remainder takes
   // the dividend's sign.
   always_comb begin
      prodFix = (signA ^ signB) ? -acc : acc;
      quoFix  = (signA ^ signB) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      remFix  = signA ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
   end

   assign busy = (state != MD_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= MD_IDLE;
         cnt   <= '0;
         acc   <= '0;
         opnd  <= '0;
         origA <= '0;
         signA <= 1'b0;
         signB <= 1'b0;
         isDiv <= 1'b0;
         bZero <= 1'b0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start && op == MD_MT) begin
                  if (mtLo) LO <= a;
                  else      HI <= a;
               end else if (start && opMd) begin
                  state <= MD_BUSY;
                  cnt   <= '0;
                  isDiv <= opDiv;
                  signA <= negA;
                  signB <= negB;
                  origA <= a;
                  bZero <= (b == '0);
                  opnd  <= opDiv ? magB : magA;
                  acc   <= {{XLEN{1'b0}}, (opDiv ? magA : magB)};
               end
            end
            MD_BUSY: begin
               if (flush) begin
                  state <= MD_IDLE;
               end else if (cnt == CW'(MD_ITER)) begin
                  state <= MD_DONE;
               end else begin
                  acc <= accNext;
                  cnt <= cnt + CW'(1);
               end
            end
            MD_DONE: begin
               state <= MD_IDLE;
               if (!flush) begin
                  if (isDiv && bZero) begin
                     HI <= origA;
                     LO <= '1;
                  end else if (isDiv) begin
                     HI <= remFix;
                     LO <= quoFix;
                  end else begin
                     HI <= prodFix[2*XLEN-1:XLEN];
                     LO <= prodFix[XLEN-1:0];
                  end
               end
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/stage_ex_muldiv.sv
// EX stage of the 5-stage MIPS pipeline: integer ALU, HI/LO read mux,
// store-data forwarding and the stall logic around the multiply/divide unit.
//   clk, rst : clock, asynchronous active-low reset
//   ex       : stage_ex_muldiv_if.slave (operands, controls, results, stall)
module stage_ex_muldiv
   import stage_ex_muldiv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MD_ITER = 32   // must equal XLEN
) (
   input  logic             clk,
   input  logic             rst,
   stage_ex_muldiv_if.slave ex
);

   logic [XLEN-1:0] aluRes, hiReg, loReg;
   logic            isMd, isMt, mdStart, mdBusy;
   mdState_e        mdState;

   always_comb begin
      case (ex.ALUctr)
         ALU_ADD:  aluRes = ex.SrcA + ex.SrcB;
         ALU_SUB:  aluRes = ex.SrcA - ex.SrcB;
         ALU_AND:  aluRes = ex.SrcA & ex.SrcB;
         ALU_OR:   aluRes = ex.SrcA | ex.SrcB;
         ALU_XOR:  aluRes = ex.SrcA ^ ex.SrcB;
         ALU_NOR:  aluRes = ~(ex.SrcA | ex.SrcB);
         ALU_SLT:  aluRes = {{(XLEN-1){1'b0}}, $signed(ex.SrcA) < $signed(ex.SrcB)};
         ALU_SLTU: aluRes = {{(XLEN-1){1'b0}}, ex.SrcA < ex.SrcB};
         ALU_SLL:  aluRes = ex.SrcB << ex.Shamt;
         ALU_SRL:  aluRes = ex.SrcB >> ex.Shamt;
         ALU_SRA:  aluRes = $unsigned($signed(ex.SrcB) >>> ex.Shamt);
         ALU_LUI:  aluRes = {ex.SrcB[15:0], {(XLEN-16){1'b0}}};
         default:  aluRes = '0;
      endcase
   end

   always_comb begin
      isMd = (ex.MD_op == MD_MULT) || (ex.MD_op == MD_MULTU) ||
             (ex.MD_op == MD_DIV)  || (ex.MD_op == MD_DIVU);
      isMt = (ex.MD_op == MD_MT);
      // mthi/mtlo writes in IDLE regardless of mem_stall: repeating the
      // same write while the instruction is held is harmless.
      mdStart = !mdBusy && !ex.flush && ((isMd && !ex.mem_stall) || isMt);
   end

   // Stall sources: the accept cycle itself, every BUSY cycle, and any
   // HI/LO-related op sitting in EX while DONE is committing. A flush kills
   // the EX instruction, so it drops the stall in the same cycle; reset
   // gating keeps the stall low while the unit is held in reset.
   always_comb begin
      ex.ex_stall = rst && !ex.flush &&
                    ((!mdBusy && isMd && !ex.mem_stall) ||
                     (mdState == MD_BUSY) ||
                     (mdState == MD_DONE && ex.MD_op != MD_NONE));
   end

   always_comb begin
      if (ex.MD_op == MD_MFHI)      ex.ALUres = hiReg;
      else if (ex.MD_op == MD_MFLO) ex.ALUres = loReg;
      else                          ex.ALUres = aluRes;
      ex.Zero    = (ex.ALUres == '0);
      ex.MemWd   = ex.SrcB;
      ex.HI      = hiReg;
      ex.LO      = loReg;
      ex.mdState = mdState;
   end

   stage_ex_muldiv_muldiv_unit #(
      .XLEN    (XLEN),
      .MD_ITER (MD_ITER)
   ) uMulDiv (
      .clk   (clk),
      .rst   (rst),
      .op    (ex.MD_op),
      .a     (ex.SrcA),
      .b     (ex.SrcB),
      .start (mdStart),
      .mtLo  (ex.Shamt[0]),
      .flush (ex.flush),
      .busy  (mdBusy),
      .state (mdState),
      .HI    (hiReg),
      .LO    (loReg)
   );

endmodule

// File: tb/tb_stage_ex_muldiv.sv
// Self-checking bench for stage_ex_muldiv: ALU sweep, mul/div results and
// stall length, HI/LO hazard, mthi/mtlo, accept blocking, flush and reset abort.
module tb_stage_ex_muldiv;
   import stage_ex_muldiv_pkg::*;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   stage_ex_muldiv_if #(.XLEN(XLEN)) exIf ();

   stage_ex_muldiv #(.XLEN(XLEN), .MD_ITER(32)) dut (
      .clk (clk),
      .rst (rst),
      .ex  (exIf)
   );

   int              testsRun    = 0;
   int              testsFailed = 0;
   logic [XLEN-1:0] expQ[$];
   logic [XLEN-1:0] curHi, curLo;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic checkVal(input string tag, input logic [XLEN-1:0] got,
                           input logic [XLEN-1:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic popCheck(input string tag, input logic [XLEN-1:0] got);
      if (expQ.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("FAIL %s: got 0x%08h expected <empty scoreboard>", tag, got);
      end else begin
         checkVal(tag, got, expQ.pop_front());
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void mdModel(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] hi,
                                   output logic [31:0] lo);
      logic [63:0] p;
      longint      sa, sb, q, r;
      sa = longint'({{32{a[31]}}, a});
      sb = longint'({{32{b[31]}}, b});
      p  = '0;
      q  = 0;
      r  = 0;
      case (op)
         MD_MULT:  p = 64'(sa * sb);
         MD_MULTU: p = {32'b0, a} * {32'b0, b};
         MD_DIV: if (b != 0) begin q = sa / sb; r = sa % sb; end
         MD_DIVU: if (b != 0) begin q = longint'({32'b0, a}) / longint'({32'b0, b});
                                    r = longint'({32'b0, a}) % longint'({32'b0, b}); end
         default: p = '0;
      endcase
      if (op == MD_MULT || op == MD_MULTU) begin
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else begin
         hi = 32'(r);
         lo = 32'(q);
      end
   endfunction

   // ---------------- drivers ----------------
   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic aluCase(input string tag, input aluOp_e ctr, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] res);
      nextCycle();
      exIf.ALUctr = ctr;
      exIf.SrcA   = a;
      exIf.SrcB   = b;
      exIf.Shamt  = sh;
      exIf.MD_op  = MD_NONE;
      expQ.push_back(res);
      #1;
      popCheck(tag, exIf.ALUres);
      checkVal({tag, "_zero"}, 32'(exIf.Zero), 32'(res == 32'h0));
   endtask

   task automatic runMd(input string tag, input mdOp_e op, input logic [31:0] a,
                        input logic [31:0] b, input mdOp_e followOp,
                        input int expStall);
      logic [31:0] eh, el;
      int          n;
      mdModel(op, a, b, eh, el);
      expQ.push_back(eh);
      expQ.push_back(el);
      nextCycle();
      exIf.SrcA  = a;
      exIf.SrcB  = b;
      exIf.MD_op = op;
      #1;
      checkVal({tag, "_accept_stall"}, 32'(exIf.ex_stall), 32'd1);
      nextCycle();
      exIf.MD_op = followOp;
      #1;
      n = 0;
      while (exIf.ex_stall === 1'b1 && n < 200) begin
         n++;
         nextCycle();
         #1;
      end
      checkVal({tag, "_stall_cycles"}, n, expStall);
      if (followOp == MD_NONE) begin
         nextCycle();
         #1;
      end
      popCheck({tag, "_hi"}, exIf.HI);
      popCheck({tag, "_lo"}, exIf.LO);
      if (followOp == MD_MFLO) checkVal({tag, "_mflo_res"}, exIf.ALUres, el);
      curHi = eh;
      curLo = el;
      exIf.MD_op = MD_NONE;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst            = 1'b0;
      exIf.SrcA      = '0;
      exIf.SrcB      = '0;
      exIf.Shamt     = '0;
      exIf.ALUctr    = '0;
      exIf.MD_op     = MD_NONE;
      exIf.mem_stall = 1'b0;
      exIf.flush     = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checkVal("reset_hi", exIf.HI, 32'h0);
      checkVal("reset_lo", exIf.LO, 32'h0);
      checkVal("reset_stall", 32'(exIf.ex_stall), 32'd0);
      checkVal("reset_state", 32'(exIf.mdState), 32'(MD_IDLE));
      rst = 1'b1;

      // ALU sweep
      aluCase("add_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0);
      aluCase("sub",      ALU_SUB,  32'h5, 32'h7, 5'd0, 32'hFFFF_FFFE);
      aluCase("and",      ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000);
      aluCase("or",       ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0);
      aluCase("xor",      ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0);
      aluCase("nor",      ALU_NOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h000F_000F);
      aluCase("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1);
      aluCase("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0);
      aluCase("sll",      ALU_SLL,  32'h0, 32'h1, 5'd31, 32'h8000_0000);
      aluCase("srl",      ALU_SRL,  32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000);
      aluCase("sra",      ALU_SRA,  32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000);
      aluCase("lui",      ALU_LUI,  32'h0, 32'h1234_ABCD, 5'd0, 32'hABCD_0000);
      aluCase("ctr12",    aluOp_e'(4'd12), 32'h5, 32'h7, 5'd0, 32'h0);
      checkVal("memwd", exIf.MemWd, 32'h1234_ABCD - 32'h1234_ABCD + 32'h7);

      // mthi / mtlo / mfhi / mflo
      nextCycle();
      exIf.ALUctr = ALU_ADD;
      exIf.SrcA   = 32'h1234_5678;
      exIf.Shamt  = 5'd0;
      exIf.MD_op  = MD_MT;
      #1;
      checkVal("mthi_stall", 32'(exIf.ex_stall), 32'd0);
      nextCycle();
      exIf.SrcA  = 32'hCAFE_F00D;
      exIf.Shamt = 5'd1;
      #1;
      checkVal("mthi_hi", exIf.HI, 32'h1234_5678);
      nextCycle();
      exIf.MD_op = MD_MFHI;
      #1;
      checkVal("mtlo_lo", exIf.LO, 32'hCAFE_F00D);
      checkVal("mfhi_res", exIf.ALUres, 32'h1234_5678);
      exIf.MD_op = MD_MFLO;
      #1;
      checkVal("mflo_res", exIf.ALUres, 32'hCAFE_F00D);

      // accept blocked by mem_stall, then by flush
      nextCycle();
      exIf.SrcA      = 32'd3;
      exIf.SrcB      = 32'd4;
      exIf.MD_op     = MD_MULT;
      exIf.mem_stall = 1'b1;
      #1;
      checkVal("memstall_nostall", 32'(exIf.ex_stall), 32'd0);
      nextCycle();
      #1;
      checkVal("memstall_idle", 32'(exIf.mdState), 32'(MD_IDLE));
      exIf.mem_stall = 1'b0;
      exIf.flush     = 1'b1;
      #1;
      checkVal("flushacc_nostall", 32'(exIf.ex_stall), 32'd0);
      nextCycle();
      exIf.flush = 1'b0;
      exIf.MD_op = MD_NONE;
      #1;
      checkVal("flushacc_idle", 32'(exIf.mdState), 32'(MD_IDLE));
      checkVal("flushacc_hi", exIf.HI, 32'h1234_5678);

      // mul/div results and stall length
      runMd("mult",    MD_MULT,  32'hFFFF_FFFD, 32'd7, MD_NONE, 33);
      runMd("multu",   MD_MULTU, 32'hFFFF_FFFD, 32'd7, MD_NONE, 33);
      runMd("div",     MD_DIV,   32'hFFFF_FFF9, 32'd2, MD_NONE, 33);
      runMd("divu_z",  MD_DIVU,  32'd5, 32'd0, MD_NONE, 33);
      runMd("div_z",   MD_DIV,   32'hFFFF_FFF9, 32'd0, MD_NONE, 33);
      runMd("div_ovf", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, MD_NONE, 33);
      runMd("divu_r",  MD_DIVU,  32'($urandom_range(1000000, 1)),
            32'($urandom_range(999, 1)), MD_NONE, 33);
      runMd("hazard",  MD_MULT,  32'd12345, 32'hFFFF_FFF7, MD_MFLO, 34);

      // flush in BUSY: HI/LO keep the previous result
      nextCycle();
      exIf.SrcA  = 32'd5;
      exIf.SrcB  = 32'd6;
      exIf.MD_op = MD_MULT;
      nextCycle();
      exIf.MD_op = MD_NONE;
      repeat (9) nextCycle();
      #1;
      checkVal("flush_busy", 32'(exIf.mdState), 32'(MD_BUSY));
      exIf.flush = 1'b1;
      #1;
      checkVal("flush_stall", 32'(exIf.ex_stall), 32'd0);
      nextCycle();
      exIf.flush = 1'b0;
      #1;
      checkVal("flush_idle", 32'(exIf.mdState), 32'(MD_IDLE));
      checkVal("flush_hi", exIf.HI, curHi);
      checkVal("flush_lo", exIf.LO, curLo);

      // reset in BUSY: abort and clear HI/LO at once
      nextCycle();
      exIf.SrcA  = 32'd7;
      exIf.SrcB  = 32'd9;
      exIf.MD_op = MD_MULT;
      nextCycle();
      repeat (4) nextCycle();
      #1;
      checkVal("rst_busy_stall", 32'(exIf.ex_stall), 32'd1);
      rst = 1'b0;
      #1;
      checkVal("rst_hi", exIf.HI, 32'h0);
      checkVal("rst_lo", exIf.LO, 32'h0);
      checkVal("rst_stall", 32'(exIf.ex_stall), 32'd0);
      checkVal("rst_state", 32'(exIf.mdState), 32'(MD_IDLE));
      nextCycle();
      exIf.MD_op = MD_NONE;
      rst        = 1'b1;
      #1;
      checkVal("rst_release_stall", 32'(exIf.ex_stall), 32'd0);

      if (expQ.size() != 0) checkVal("scoreboard_empty", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
